// File: rtl/data_mem_access.sv
// data_mem_access: data-memory stage fed by the LUT address stage.
// Accepts a request (req_valid/req_ready), then performs a 1..4 byte read
// or fill burst on an internal 2**ADDR_W x DATA_W memory, one beat per cycle.
// Read beats come back on rdata with rdata_valid; done pulses after the last beat.
// Optional build macro: MEM_CLEAR_ON_RESET_EN -- zero the whole memory after reset.
module data_mem_access #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_XFER   = 2'd1,
        S_FINISH = 2'd2
`ifdef MEM_CLEAR_ON_RESET_EN
        , S_CLEAR = 2'd3
`endif
    } state_t;

`ifdef MEM_CLEAR_ON_RESET_EN
    // Leaving reset starts a full clear sweep, so the block is busy and not ready.
    localparam state_t RST_STATE = S_CLEAR;
    localparam logic   RST_READY = 1'b0;
    localparam logic   RST_BUSY  = 1'b1;
`else
    localparam state_t RST_STATE = S_IDLE;
    localparam logic   RST_READY = 1'b1;
    localparam logic   RST_BUSY  = 1'b0;
`endif

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [1:0]        beats_left_q, beats_left_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              req_ready_q, req_ready_d;

    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    // Next-state, beat sequencing and memory write-enable decode.
    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        beats_left_d  = beats_left_q;
        wr_d          = wr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        busy_d        = busy_q;
        req_ready_d   = req_ready_q;
        mem_we        = 1'b0;
        mem_wdata     = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cur_addr_d   = req_addr;
                    beats_left_d = req_len;
                    wr_d         = req_write;
                    wdata_d      = req_wdata;
                    state_d      = S_XFER;
                    req_ready_d  = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            S_XFER: begin
                if (wr_q) begin
                    mem_we = 1'b1;
                end else begin
                    rdata_d       = mem[cur_addr_q];
                    rdata_valid_d = 1'b1;
                end
                // Address wraps naturally at the top of memory.
                cur_addr_d = cur_addr_q + 1'b1;
                if (beats_left_q == 2'd0) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end else begin
                    beats_left_d = beats_left_q - 2'd1;
                end
            end
            S_FINISH: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
`ifdef MEM_CLEAR_ON_RESET_EN
            S_CLEAR: begin
                mem_we     = 1'b1;
                mem_wdata  = '0;
                cur_addr_d = cur_addr_q + 1'b1;
                if (cur_addr_q == {ADDR_W{1'b1}}) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
`endif
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Control and output registers; reset aborts any burst in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= RST_STATE;
            cur_addr_q    <= '0;
            beats_left_q  <= '0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= RST_BUSY;
            req_ready_q   <= RST_READY;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            beats_left_q  <= beats_left_d;
            wr_q          <= wr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            req_ready_q   <= req_ready_d;
        end
    end

    // Memory array: contents survive reset, written one byte per beat.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[cur_addr_q] <= mem_wdata;
        end
    end

    assign req_ready   = req_ready_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Self-checking bench for data_mem_access: directed scenarios plus random
// bursts compared against a byte-array model of the memory.
module tb_data_mem_access;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = '0;
    logic [1:0] req_len = '0;
    logic [7:0] req_wdata = '0;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       done;
    logic       busy;

`ifdef MEM_CLEAR_ON_RESET_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    // Reference memory
    logic [7:0] mdl [0:255];

    // Observations collected by run_req
    int         obs_n;
    logic [7:0] obs_beat   [0:7];
    int         obs_beat_j [0:7];
    int         obs_done_n;
    int         obs_done_j;
    int         obs_busy_n;
    int         obs_ready_j;
    bit         obs_timeout;

    data_mem_access #(.DATA_W(8), .ADDR_W(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic mdl_write(input logic [7:0] a, input logic [1:0] len, input logic [7:0] wd);
        for (int k = 0; k <= int'(len); k++) mdl[(int'(a) + k) % 256] = wd;
    endtask

    // Issue one request and record what comes back, indexed by cycles after acceptance.
    task automatic run_req(input bit w, input logic [7:0] a, input logic [1:0] len, input logic [7:0] wd);
        int guard;
        obs_n = 0; obs_done_n = 0; obs_done_j = -1; obs_busy_n = 0; obs_ready_j = -1; obs_timeout = 0;
        @(negedge Clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = len; req_wdata = wd;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 1000) begin
            @(negedge Clk);
            guard++;
        end
        if (guard >= 1000) begin
            obs_timeout = 1;
            req_valid = 1'b0;
            return;
        end
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = 8'($urandom); req_len = 2'($urandom); req_wdata = 8'($urandom);
        for (int j = 0; j <= int'(len) + 3; j++) begin
            if (j > 0) @(negedge Clk);
            if (rdata_valid === 1'b1 && obs_n < 8) begin
                obs_beat[obs_n] = rdata; obs_beat_j[obs_n] = j; obs_n++;
            end
            if (done === 1'b1) begin obs_done_n++; obs_done_j = j; end
            if (busy === 1'b1) obs_busy_n++;
            if (req_ready === 1'b1 && obs_ready_j < 0) obs_ready_j = j;
        end
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (req_ready !== 1'b1 && cycles < 400) begin
            cycles++;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset;
        int cyc;
        #2 Reset = 1'b1;
        #1;
        total++; if (req_ready !== ~CLR) begin bad++; $display("FAIL reset_ready got=%b want=%b", req_ready, ~CLR); end
        total++; if (busy !== CLR) begin bad++; $display("FAIL reset_busy got=%b want=%b", busy, CLR); end
        total++; if (rdata !== 8'h00 || rdata_valid !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_outs got rdata=%h vld=%b done=%b want 00/0/0", rdata, rdata_valid, done); end
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        wait_ready(cyc);
        total++; if (req_ready !== 1'b1 || cyc != (CLR ? 256 : 0)) begin
            bad++; $display("FAIL reset_release ready=%b cycles=%0d want ready=1 cycles=%0d", req_ready, cyc, CLR ? 256 : 0); end
        if (CLR) for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    endtask

    // Give every byte a known value so all later reads are predictable.
    task automatic test_fill_all;
        int badfill = 0;
        for (int a = 0; a < 256; a += 4) begin
            logic [7:0] wd = 8'($urandom);
            run_req(1'b1, 8'(a), 2'd3, wd);
            mdl_write(8'(a), 2'd3, wd);
            if (obs_timeout || obs_n != 0 || obs_done_n != 1 || obs_busy_n != 5) badfill++;
        end
        total++; if (badfill != 0) begin bad++; $display("FAIL fill_writes got=%0d bad writes want=0", badfill); end
    endtask

    task automatic test_single;
        run_req(1'b1, 8'h05, 2'd0, 8'hA5);
        mdl_write(8'h05, 2'd0, 8'hA5);
        total++; if (obs_timeout || obs_n != 0 || obs_done_n != 1 || obs_done_j != 1) begin
            bad++; $display("FAIL single_write to=%0b beats=%0d done_n=%0d done_j=%0d want 0/0/1/1", obs_timeout, obs_n, obs_done_n, obs_done_j); end
        run_req(1'b0, 8'h05, 2'd0, 8'h00);
        total++; if (obs_n != 1 || obs_beat[0] !== 8'hA5 || obs_beat_j[0] != 1) begin
            bad++; $display("FAIL single_read beats=%0d data=%h at=%0d want 1 beat A5 at 1", obs_n, obs_beat[0], obs_beat_j[0]); end
        total++; if (obs_done_n != 1 || obs_done_j != 1 || obs_ready_j != 2) begin
            bad++; $display("FAIL single_done done_n=%0d done_j=%0d ready_j=%0d want 1/1/2", obs_done_n, obs_done_j, obs_ready_j); end
    endtask

    task automatic test_burst;
        logic [7:0] prior = mdl[8'h0F];
        run_req(1'b1, 8'h10, 2'd3, 8'h3C);
        mdl_write(8'h10, 2'd3, 8'h3C);
        total++; if (obs_busy_n != 5 || obs_n != 0) begin
            bad++; $display("FAIL burst_write busy=%0d beats=%0d want 5/0", obs_busy_n, obs_n); end
        run_req(1'b0, 8'h0F, 2'd3, 8'h00);
        total++; if (obs_n != 4 || obs_beat[0] !== prior || obs_beat[1] !== 8'h3C || obs_beat[2] !== 8'h3C || obs_beat[3] !== 8'h3C) begin
            bad++; $display("FAIL burst_read n=%0d got %h %h %h %h want %h 3c 3c 3c", obs_n, obs_beat[0], obs_beat[1], obs_beat[2], obs_beat[3], prior); end
        total++; if (obs_beat_j[0] != 1 || obs_beat_j[3] != 4 || obs_done_j != 4 || obs_busy_n != 5) begin
            bad++; $display("FAIL burst_timing first=%0d last=%0d done=%0d busy=%0d want 1/4/4/5", obs_beat_j[0], obs_beat_j[3], obs_done_j, obs_busy_n); end
    endtask

    task automatic test_wrap;
        logic [7:0] keep = mdl[8'h02];
        run_req(1'b1, 8'hFE, 2'd3, 8'h77);
        mdl_write(8'hFE, 2'd3, 8'h77);
        run_req(1'b0, 8'hFE, 2'd3, 8'h00);
        total++; if (obs_n != 4 || obs_beat[0] !== 8'h77 || obs_beat[1] !== 8'h77 || obs_beat[2] !== 8'h77 || obs_beat[3] !== 8'h77) begin
            bad++; $display("FAIL wrap_read n=%0d got %h %h %h %h want 77 x4", obs_n, obs_beat[0], obs_beat[1], obs_beat[2], obs_beat[3]); end
        run_req(1'b0, 8'h02, 2'd0, 8'h00);
        total++; if (obs_n != 1 || obs_beat[0] !== keep) begin
            bad++; $display("FAIL wrap_untouched n=%0d got=%h want=%h", obs_n, obs_beat[0], keep); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a = 8'h33, b = 8'hC8;
        logic [7:0] ea = mdl[8'h33], eb = mdl[8'hC8];
        int   rdy_err = 0, nv = 0, nd = 0;
        logic [7:0] v [0:7];
        int   vj [0:7];
        int   guard = 0;
        @(negedge Clk);
        while (req_ready !== 1'b1 && guard < 100) begin @(negedge Clk); guard++; end
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = 2'd0;
        @(posedge Clk);
        for (int j = 0; j <= 7; j++) begin
            @(negedge Clk);
            if (j == 0) req_addr = b;
            if (req_ready !== ((j == 2) || (j >= 5))) rdy_err++;
            if (rdata_valid === 1'b1 && nv < 8) begin v[nv] = rdata; vj[nv] = j; nv++; end
            if (done === 1'b1) nd++;
            if (j == 2) begin
                total++; if (rdata !== ea) begin bad++; $display("FAIL b2b_hold got=%h want=%h", rdata, ea); end
            end
            if (j == 3) req_valid = 1'b0;
        end
        total++; if (rdy_err != 0 || guard >= 100) begin
            bad++; $display("FAIL b2b_ready pattern errors=%0d guard=%0d want 0", rdy_err, guard); end
        total++; if (nv != 2 || nd != 2) begin
            bad++; $display("FAIL b2b_count beats=%0d dones=%0d want 2/2", nv, nd); end
        else begin
            total++; if (v[0] !== ea || vj[0] != 1 || v[1] !== eb || vj[1] != 4) begin
                bad++; $display("FAIL b2b_data got %h@%0d %h@%0d want %h@1 %h@4", v[0], vj[0], v[1], vj[1], ea, eb); end
        end
    endtask

    task automatic test_reset_abort;
        int cyc;
        @(negedge Clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40; req_len = 2'd3;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 100) begin @(negedge Clk); cyc++; end
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
        @(negedge Clk);
        total++; if (rdata_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL abort_pre vld=%b busy=%b want 1/1", rdata_valid, busy); end
        Reset = 1'b1;
        #1;
        total++; if (rdata_valid !== 1'b0 || done !== 1'b0 || busy !== CLR || req_ready !== ~CLR) begin
            bad++; $display("FAIL abort_async vld=%b done=%b busy=%b ready=%b want 0/0/%b/%b", rdata_valid, done, busy, req_ready, CLR, ~CLR); end
        @(negedge Clk);
        Reset = 1'b0;
        wait_ready(cyc);
        if (CLR) for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        run_req(1'b0, 8'h41, 2'd1, 8'h00);
        total++; if (obs_n != 2 || obs_beat[0] !== mdl[8'h41] || obs_beat[1] !== mdl[8'h42] || obs_done_n != 1) begin
            bad++; $display("FAIL abort_next n=%0d got %h %h done=%0d want %h %h 1", obs_n, obs_beat[0], obs_beat[1], obs_done_n, mdl[8'h41], mdl[8'h42]); end
    endtask

    task automatic test_random;
        int errs = 0;
        for (int t = 0; t < 40; t++) begin
            bit         w  = 1'($urandom);
            logic [7:0] a  = 8'($urandom);
            logic [1:0] ln = 2'($urandom);
            logic [7:0] wd = 8'($urandom);
            run_req(w, a, ln, wd);
            if (obs_timeout || obs_done_n != 1 || obs_done_j != int'(ln) + 1 || obs_busy_n != int'(ln) + 2 || obs_ready_j != int'(ln) + 2) errs++;
            if (w) begin
                if (obs_n != 0) errs++;
                mdl_write(a, ln, wd);
            end else begin
                if (obs_n != int'(ln) + 1) errs++;
                else for (int k = 0; k <= int'(ln); k++)
                    if (obs_beat[k] !== mdl[(int'(a) + k) % 256] || obs_beat_j[k] != k + 1) errs++;
            end
        end
        total++; if (errs != 0) begin bad++; $display("FAIL random_mix errors=%0d want 0", errs); end
    endtask

`ifdef MEM_CLEAR_ON_RESET_EN
    task automatic test_clear;
        int cyc;
        run_req(1'b1, 8'h80, 2'd0, 8'hFF);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        wait_ready(cyc);
        total++; if (cyc != 256) begin bad++; $display("FAIL clear_cycles got=%0d want=256", cyc); end
        run_req(1'b0, 8'h80, 2'd0, 8'h00);
        total++; if (obs_n != 1 || obs_beat[0] !== 8'h00) begin
            bad++; $display("FAIL clear_read n=%0d got=%h want 00", obs_n, obs_beat[0]); end
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        test_reset;
        test_fill_all;
        test_single;
        test_burst;
        test_wrap;
        test_back_to_back;
        test_reset_abort;
        test_random;
`ifdef MEM_CLEAR_ON_RESET_EN
        test_clear;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
